// File: rtl/key_event_decoder.sv
// Per-key event decoder: turns a debounced key level into single-cycle press,
// release, long-press and auto-repeat strobes, plus a saturating repeat count.
module key_event_decoder #(
   parameter bit          ACTIVE_LOW    = 1'b1,
   parameter int unsigned LONG_CYCLES   = 25_000_000,
   parameter int unsigned REPEAT_CYCLES = 5_000_000,
   parameter int unsigned CNT_W         = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       key_in,
   output logic       pressed,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_pulse,
   output logic       repeat_pulse,
   output logic [7:0] repeat_count
);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      REPEAT
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [7:0]       count_next;
   logic             k, k_q, k_prev;
   logic             press_next, release_next, long_next, repeat_next;

   assign k       = key_in ^ ACTIVE_LOW;
   assign pressed = k_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         // Preloading both taps with the live level hides a key held through reset.
         k_q           <= k;
         k_prev        <= k;
         state         <= IDLE;
         cnt           <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
         repeat_count  <= '0;
      end else begin
         k_q           <= k;
         k_prev        <= k_q;
         state         <= state_next;
         cnt           <= cnt_next;
         press_pulse   <= press_next;
         release_pulse <= release_next;
         long_pulse    <= long_next;
         repeat_pulse  <= repeat_next;
         repeat_count  <= count_next;
      end
   end

   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      count_next   = repeat_count;
      press_next   = 1'b0;
      release_next = 1'b0;
      long_next    = 1'b0;
      repeat_next  = 1'b0;

      if (!enable) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (k_q && !k_prev) begin
                  press_next = 1'b1;
                  state_next = HOLD;
                  cnt_next   = '0;
                  count_next = '0;
               end
            end
            HOLD: begin
               // Release is tested first so it wins over a coincident terminal count.
               if (!k_q) begin
                  release_next = 1'b1;
                  state_next   = IDLE;
                  cnt_next     = '0;
               end else if (cnt == LONG_LAST) begin
                  long_next  = 1'b1;
                  state_next = REPEAT;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
            REPEAT: begin
               if (!k_q) begin
                  release_next = 1'b1;
                  state_next   = IDLE;
                  cnt_next     = '0;
               end else if (cnt == REPEAT_LAST) begin
                  repeat_next = 1'b1;
                  cnt_next    = '0;
                  if (repeat_count != '1) begin
                     count_next = repeat_count + 8'd1;
                  end
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4,
// active-low key: vector table for short sequences, hand sequences for long holds.
module tb_key_event_decoder;

   localparam int LC = 8;
   localparam int RC = 4;

   logic       clk = 1'b0;
   logic       rst, enable, key_in;
   logic       pressed, press_pulse, release_pulse, long_pulse, repeat_pulse;
   logic [7:0] repeat_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       p;
      logic       en;
      logic       exp_pressed;
      logic [3:0] exp_str;   // {press, release, long, repeat}
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   key_event_decoder #(
      .ACTIVE_LOW   (1'b1),
      .LONG_CYCLES  (LC),
      .REPEAT_CYCLES(RC),
      .CNT_W        (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .key_in       (key_in),
      .pressed      (pressed),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse),
      .repeat_count (repeat_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] strobes();
      return {press_pulse, release_pulse, long_pulse, repeat_pulse};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_key(input logic p);
      key_in = ~p;
   endtask

   task automatic add(input logic p, input logic en, input logic ep, input logic [3:0] es);
      vec_t v;
      v.p = p; v.en = en; v.exp_pressed = ep; v.exp_str = es;
      vecs.push_back(v);
   endtask

   // Drives a fresh press from IDLE; returns with the bench in cycle P.
   task automatic press_start(input string tag);
      set_key(1'b1);
      enable = 1'b1;
      step();
      check({tag, "_pressed"}, 32'(pressed), 32'd1);
      check({tag, "_pre_str"}, 32'(strobes()), 32'h0);
      step();
      check({tag, "_press"}, 32'(strobes()), 32'h8);
      check({tag, "_cnt_clr"}, 32'(repeat_count), 32'd0);
   endtask

   // Checks cycles P+1..P+n against the long/repeat timing formula.
   task automatic hold_run(input int n, input string tag);
      int exp_c;
      logic el, er;
      for (int k = 1; k <= n; k++) begin
         step();
         el    = (k == LC);
         er    = (k > LC) && ((k - LC) % RC == 0);
         exp_c = (k >= LC + RC) ? (k - LC) / RC : 0;
         if (exp_c > 255) exp_c = 255;
         check({tag, "_str"}, 32'(strobes()), 32'({2'b00, el, er}));
         check({tag, "_cnt"}, 32'(repeat_count), 32'(exp_c));
      end
   endtask

   task automatic release_run(input string tag, input int exp_c);
      set_key(1'b0);
      step();
      check({tag, "_rel_pre"}, 32'(strobes()), 32'h0);
      step();
      check({tag, "_rel"}, 32'(strobes()), 32'h4);
      check({tag, "_rel_cnt"}, 32'(repeat_count), 32'(exp_c));
      step();
      check({tag, "_rel_after"}, 32'(strobes()), 32'h0);
      check({tag, "_cnt_hold"}, 32'(repeat_count), 32'(exp_c));
   endtask

   initial begin
      // Short press: press two cycles after key goes down, release two after it goes up.
      add(1,1,1,4'h0); add(1,1,1,4'h8); add(1,1,1,4'h0); add(1,1,1,4'h0);
      add(0,1,0,4'h0); add(0,1,0,4'h4); add(0,1,0,4'h0);
      // Release coincides with the long terminal count: release only.
      add(1,1,1,4'h0); add(1,1,1,4'h8);
      for (int i = 0; i < 6; i++) add(1,1,1,4'h0);
      add(0,1,0,4'h0); add(0,1,0,4'h4); add(0,1,0,4'h0);
      // Release one cycle later: long fires, then release.
      add(1,1,1,4'h0); add(1,1,1,4'h8);
      for (int i = 0; i < 7; i++) add(1,1,1,4'h0);
      add(0,1,0,4'h2); add(0,1,0,4'h4); add(0,1,0,4'h0);
      // Enable low during press, raised while held, then re-press and disable mid-hold.
      add(1,0,1,4'h0); add(1,0,1,4'h0); add(1,1,1,4'h0); add(1,1,1,4'h0);
      add(0,1,0,4'h0); add(0,1,0,4'h0); add(1,1,1,4'h0); add(1,1,1,4'h8);
      add(1,0,1,4'h0); add(0,0,0,4'h0); add(0,1,0,4'h0); add(0,1,0,4'h0);

      rst = 1'b1;
      enable = 1'b1;
      set_key(1'b0);
      step();
      step();
      check("reset_pressed", 32'(pressed), 32'd0);
      check("reset_str", 32'(strobes()), 32'h0);
      check("reset_cnt", 32'(repeat_count), 32'd0);
      rst = 1'b0;
      step();
      check("idle_str", 32'(strobes()), 32'h0);

      foreach (vecs[i]) begin
         set_key(vecs[i].p);
         enable = vecs[i].en;
         step();
         check($sformatf("vec%0d_pressed", i), 32'(pressed), 32'(vecs[i].exp_pressed));
         check($sformatf("vec%0d_str", i), 32'(strobes()), 32'(vecs[i].exp_str));
      end

      press_start("hold20");
      hold_run(20, "hold20");
      release_run("hold20", 3);

      press_start("sat");
      hold_run(LC + 1300, "sat");
      release_run("sat", 255);

      // Reset while in REPEAT with the key held, then keep it held through reset.
      press_start("rstrep");
      hold_run(LC + RC, "rstrep");
      rst = 1'b1;
      step();
      check("rstrep_str", 32'(strobes()), 32'h0);
      check("rstrep_cnt", 32'(repeat_count), 32'd0);
      check("rstrep_pressed", 32'(pressed), 32'd1);
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("held_thru_rst_str", 32'(strobes()), 32'h0);
         check("held_thru_rst_pressed", 32'(pressed), 32'd1);
      end
      set_key(1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("rel_after_rst_str", 32'(strobes()), 32'h0);
         check("rel_after_rst_pressed", 32'(pressed), 32'd0);
      end
      press_start("repress");
      release_run("repress", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
